// File: rtl/tpu_pkg.sv
// tpu_pkg: TPU register-bus address map and host sequencer state encoding.
package tpu_pkg;

   localparam logic [15:0] A_BASE      = 16'h0100;
   localparam logic [15:0] B_BASE      = 16'h0200;
   localparam logic [15:0] C_BASE      = 16'h0300;
   localparam logic [15:0] MATMUL_ADDR = 16'h0400;
   localparam logic [15:0] IDLE_ADDR   = 16'h0000;

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, LOAD_C, TRIGGER, WAIT, READ_C, FIN
   } state_e;

endpackage

// File: rtl/tpu_out_reg.sv
// tpu_out_reg: one-entry valid/ready output register for result words.
// ready_o tells the producer a word loaded this cycle will be accepted:
// either the entry is empty or its current word drains this cycle.
module tpu_out_reg #(
   parameter int DATAW = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [DATAW-1:0] data_i,
   output logic             ready_o,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [DATAW-1:0] out_data_o
);
   logic             valid_q;
   logic [DATAW-1:0] data_q;

   assign ready_o     = ~valid_q | out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   // Capture on load; otherwise empty once the consumer takes the word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: streams A and B (and optionally C) operand rows into the
// TPU over its register bus, triggers MatMul, waits for the array to settle,
// then reads the C result rows out through a valid/ready stream.
// Optional feature macro: TPU_HOST_CLOAD_EN -- when defined, C is loaded from
// the operand stream; otherwise C is cleared with back-to-back zero writes.
// Bus writes are registered (one cycle after the handshake); reads drive addr
// combinationally so dataIn can be captured in the same cycle.
module tpu_host_sequencer
   import tpu_pkg::*;
#(
   parameter int DIM         = 8,
   parameter int ADDRW       = 16,
   parameter int DATAW       = 64,
   parameter int WAIT_CYCLES = 3*DIM
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             r_w,
   output logic [ADDRW-1:0] addr,
   output logic [DATAW-1:0] dataOut,
   input  logic [DATAW-1:0] dataIn
);
   localparam int         WCW     = $clog2(WAIT_CYCLES + 2);
   localparam logic [4:0] LAST_AB = 5'(DIM - 1);
   localparam logic [4:0] LAST_C  = 5'(2*DIM - 1);
   localparam logic [4:0] NUM_C   = 5'(2*DIM);

   state_e           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             bus_w_q, bus_w_d;
   logic [ADDRW-1:0] bus_a_q, bus_a_d;
   logic [DATAW-1:0] bus_dat_q, bus_dat_d;
   logic [ADDRW-1:0] base, cur_addr;
   logic             hs, rd_go, or_rdy;

   assign hs = in_valid & in_ready;

   tpu_out_reg #(.DATAW(DATAW)) u_out (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (rd_go),
      .data_i      (dataIn),
      .ready_o     (or_rdy),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data)
   );

   // State, counters and the registered bus command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wcnt_q    <= '0;
         bus_w_q   <= 1'b0;
         bus_a_q   <= '0;
         bus_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wcnt_q    <= wcnt_d;
         bus_w_q   <= bus_w_d;
         bus_a_q   <= bus_a_d;
         bus_dat_q <= bus_dat_d;
      end
   end

   // Next state, word/wait counters and the bus command for next cycle.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wcnt_d    = wcnt_q;
      bus_w_d   = 1'b0;
      bus_a_d   = ADDRW'(IDLE_ADDR);
      bus_dat_d = '0;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD_A;
            idx_d   = '0;
         end
         LOAD_A, LOAD_B: if (hs) begin
            bus_w_d   = 1'b1;
            bus_a_d   = cur_addr;
            bus_dat_d = in_data;
            if (idx_q == LAST_AB) begin
               state_d = (state_q == LOAD_A) ? LOAD_B : LOAD_C;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         LOAD_C: begin
`ifdef TPU_HOST_CLOAD_EN
            if (hs) begin
               bus_w_d   = 1'b1;
               bus_a_d   = cur_addr;
               bus_dat_d = in_data;
`else
            begin
               bus_w_d   = 1'b1;
               bus_a_d   = cur_addr;
               bus_dat_d = '0;
`endif
               if (idx_q == LAST_C) begin
                  state_d = TRIGGER;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         TRIGGER: begin
            bus_w_d = 1'b1;
            bus_a_d = ADDRW'(MATMUL_ADDR);
            state_d = WAIT;
            wcnt_d  = '0;
         end
         // First WAIT cycle shows the trigger write; WAIT_CYCLES idle cycles follow.
         WAIT: if (wcnt_q == WCW'(WAIT_CYCLES)) begin
            state_d = READ_C;
            idx_d   = '0;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
         READ_C: if (rd_go) begin
            idx_d = idx_q + 5'd1;
         end else if (idx_q == NUM_C && or_rdy) begin
            state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status, stream-accept, address base and bus output selection.
   always_comb begin
      busy     = (state_q != IDLE);
      done     = (state_q == FIN);
      in_ready = 1'b0;
      base     = ADDRW'(C_BASE);
      case (state_q)
         LOAD_A: begin
            in_ready = 1'b1;
            base     = ADDRW'(A_BASE);
         end
         LOAD_B: begin
            in_ready = 1'b1;
            base     = ADDRW'(B_BASE);
         end
`ifdef TPU_HOST_CLOAD_EN
         LOAD_C: in_ready = 1'b1;
`endif
         default: ;
      endcase
      cur_addr = base + ADDRW'({idx_q, 3'b000});
      rd_go    = (state_q == READ_C) && (idx_q < NUM_C) && or_rdy;
      r_w      = bus_w_q;
      addr     = rd_go ? cur_addr : bus_a_q;
      dataOut  = bus_dat_q;
   end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Bench for tpu_host_sequencer: a simple TPU register model answers the bus,
// and a count-based job model predicts every output on every cycle.
module tb_tpu_host_sequencer;
   localparam int DIM   = 8;
   localparam int ADDRW = 16;
   localparam int DATAW = 64;
   localparam int WAITC = 3*DIM;
   localparam int AIW   = $clog2(DIM);
   localparam int CIW   = $clog2(2*DIM);
`ifdef TPU_HOST_CLOAD_EN
   localparam int NSTREAM = 4*DIM;
`else
   localparam int NSTREAM = 2*DIM;
`endif

   typedef logic [DIM-1:0][DATAW-1:0]   mat_t;
   typedef logic [2*DIM-1:0][DATAW-1:0] cmat_t;

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic             in_valid = 1'b0, out_ready = 1'b1;
   logic [DATAW-1:0] in_data = '0;
   logic             busy, done, in_ready, out_valid, r_w;
   logic [DATAW-1:0] out_data, dataOut, dataIn;
   logic [ADDRW-1:0] addr;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   tpu_host_sequencer #(.DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .r_w(r_w), .addr(addr), .dataOut(dataOut), .dataIn(dataIn)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // C += A*B with 8-bit elements of A/B rows and 16-bit C elements, two words per C row.
   function automatic cmat_t matmul(input mat_t a, input mat_t b, input cmat_t c);
      cmat_t       r;
      logic [15:0] acc;
      r = c;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            acc = r[2*i + j/4][16*(j%4) +: 16];
            for (int k = 0; k < DIM; k++)
               acc = acc + {8'h00, a[i][8*k +: 8]} * {8'h00, b[k][8*j +: 8]};
            r[2*i + j/4][16*(j%4) +: 16] = acc;
         end
      return r;
   endfunction

   // ---------------- TPU register model ----------------
   mat_t  tpu_a, tpu_b;
   cmat_t tpu_c;

   always @(posedge clk) begin
      int ia;
      ia = int'(addr);
      if (rst_n && r_w) begin
         if (ia >= 'h100 && ia < 'h100 + 8*DIM)        tpu_a[AIW'((ia - 'h100) / 8)] <= dataOut;
         else if (ia >= 'h200 && ia < 'h200 + 8*DIM)   tpu_b[AIW'((ia - 'h200) / 8)] <= dataOut;
         else if (ia >= 'h300 && ia < 'h300 + 16*DIM)  tpu_c[CIW'((ia - 'h300) / 8)] <= dataOut;
         else if (ia == 'h400)                         tpu_c <= matmul(tpu_a, tpu_b, tpu_c);
      end
   end

   always_comb begin
      int ra;
      ra     = int'(addr);
      dataIn = '0;
      if (ra >= 'h300 && ra < 'h300 + 16*DIM) dataIn = tpu_c[CIW'((ra - 'h300) / 8)];
   end

   // ---------------- job model ----------------
   bit               m_busy, m_fin, m_trig, m_full;
   int               m_nin, m_ncz, m_wait, m_nrd;
   logic             m_pw;
   logic [ADDRW-1:0] m_pa;
   logic [DATAW-1:0] m_pd, m_out;
   mat_t             m_a, m_b;
   cmat_t            m_c, m_gold;
   int               tot_wr, tot_rd, tot_done, gap_run, last_gap;
   bit               in_gap;

   function automatic logic [ADDRW-1:0] stream_addr(input int n);
      if (n < DIM)   return ADDRW'('h100 + 8*n);
      if (n < 2*DIM) return ADDRW'('h200 + 8*(n - DIM));
      return ADDRW'('h300 + 8*(n - 2*DIM));
   endfunction

   // Compare every cycle against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      bit               e_inrdy, e_rd, drained;
      logic [ADDRW-1:0] e_addr;
      if (r_w) tot_wr++;
      if (busy && !r_w && addr != '0) tot_rd++;
      if (done) tot_done++;
      if (r_w && addr == 16'h0400) begin
         in_gap = 1; gap_run = 0;
      end else if (in_gap) begin
         if (!r_w && addr == '0) gap_run++;
         else begin last_gap = gap_run; in_gap = 0; end
      end

      if (!rst_n) begin
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_done", 64'(done), 64'd0);
         chk("rst_in_ready", 64'(in_ready), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_out_data", out_data, 64'd0);
         chk("rst_r_w", 64'(r_w), 64'd0);
         chk("rst_addr", 64'(addr), 64'd0);
         chk("rst_dataOut", dataOut, 64'd0);
         m_busy = 0; m_fin = 0; m_trig = 0; m_full = 0; m_nin = 0; m_nrd = 0;
         m_pw = 0; m_pa = '0; m_pd = '0; m_out = '0; in_gap = 0;
      end else begin
         e_inrdy = m_busy && !m_fin && m_nin < NSTREAM;
         e_rd    = m_busy && !m_fin && m_trig && m_wait == 0 && m_nrd < 2*DIM &&
                   (!m_full || out_ready);
         e_addr  = e_rd ? ADDRW'('h300 + 8*m_nrd) : m_pa;
         chk("busy", 64'(busy), 64'(m_busy));
         chk("done", 64'(done), 64'(m_fin));
         chk("in_ready", 64'(in_ready), 64'(e_inrdy));
         chk("r_w", 64'(r_w), 64'(m_pw));
         chk("addr", 64'(addr), 64'(e_addr));
         chk("dataOut", dataOut, m_pd);
         chk("out_valid", 64'(out_valid), 64'(m_full));
         chk("out_data", out_data, m_out);

         m_pw = 0; m_pa = '0; m_pd = '0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_fin = 0; m_trig = 0; m_nin = 0; m_ncz = 0; m_nrd = 0;
               m_c = '0;
            end
         end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
         end else if (m_nin < NSTREAM) begin
            if (in_valid) begin
               m_pw = 1; m_pa = stream_addr(m_nin); m_pd = in_data;
               if (m_nin < DIM)        m_a[AIW'(m_nin)] = in_data;
               else if (m_nin < 2*DIM) m_b[AIW'(m_nin - DIM)] = in_data;
               else                    m_c[CIW'(m_nin - 2*DIM)] = in_data;
               m_nin++;
            end
`ifndef TPU_HOST_CLOAD_EN
         end else if (m_ncz < 2*DIM) begin
            m_pw = 1; m_pa = ADDRW'('h300 + 8*m_ncz); m_pd = '0; m_ncz++;
`endif
         end else if (!m_trig) begin
            m_pw = 1; m_pa = 16'h0400; m_trig = 1; m_wait = WAITC + 1;
            m_gold = matmul(m_a, m_b, m_c);
         end else if (m_wait > 0) begin
            m_wait--;
         end else begin
            drained = !m_full || out_ready;
            if (m_nrd == 2*DIM && drained) m_fin = 1;
            if (e_rd) begin
               m_out = m_gold[CIW'(m_nrd)]; m_full = 1; m_nrd++;
            end else if (drained) begin
               m_full = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [DATAW-1:0] first_out;

   function automatic logic [DATAW-1:0] lit_word(input int n);
      if (n < DIM)   return {8{8'h02}};
      if (n < 2*DIM) return {8{8'h03}};
      return '0;
   endfunction

   // ivm: 0 always valid, 1 toggle, 2 random; orm: 0 always ready, 1 stall 5 after first result, 2 random
   task automatic run_job(input int ivm, input int orm, input bit noise, input bit lit);
      int cyc, stall, wr0, rd0, dn0;
      bit seen_ov, tog;
      cyc = 0; stall = 0; seen_ov = 0; tog = 1;
      wr0 = tot_wr; rd0 = tot_rd; dn0 = tot_done;
      @(posedge clk); #1;
      start = 1; in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      start = 0;
      while (!done && cyc < 3000) begin
         case (ivm)
            0:       in_valid = 1;
            1:       begin in_valid = tog; tog = ~tog; end
            default: in_valid = ($urandom_range(0, 1) == 1);
         endcase
         in_data = lit ? lit_word(m_nin) : {$urandom, $urandom};
         if (out_valid && !seen_ov) begin
            seen_ov = 1; first_out = out_data;
            if (orm == 1) stall = 5;
         end
         case (orm)
            0:       out_ready = 1;
            1:       begin out_ready = (stall == 0); if (stall > 0) stall--; end
            default: out_ready = ($urandom_range(0, 2) != 0);
         endcase
         start = noise && ($urandom_range(0, 7) == 0);
         @(posedge clk); #1;
         cyc++;
      end
      start = 0; in_valid = 0; out_ready = 1;
      chk("job_done_reached", 64'(done), 64'd1);
      @(negedge clk); #1;
      chk("job_write_count", 64'(tot_wr - wr0), 64'd33);
      chk("job_read_count", 64'(tot_rd - rd0), 64'd16);
      chk("job_done_pulses", 64'(tot_done - dn0), 64'd1);
   endtask

   initial begin
      int cyc;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // Literal job: A all 2, B all 3, C zero -> every C element 8*2*3 = 0x30.
      run_job(0, 0, 0, 1);
      chk("lit_model_gold", m_gold[0], 64'h0030_0030_0030_0030);
      chk("lit_first_out", first_out, 64'h0030_0030_0030_0030);
      chk("lit_wait_gap", 64'(last_gap), 64'd24);

      run_job(1, 0, 0, 0);   // in_valid toggling
      run_job(0, 1, 0, 0);   // output stall after first result
      run_job(0, 0, 1, 0);   // stray start pulses during the job
      chk("idle_gap_random", 64'(last_gap), 64'd24);

      // Abort mid-LOAD_B after three B words.
      @(posedge clk); #1;
      start = 1; in_valid = 1; in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      start = 0; cyc = 0;
      while (m_nin < DIM + 3 && cyc < 200) begin
         in_data = {$urandom, $urandom};
         @(posedge clk); #1;
         cyc++;
      end
      chk("abort_reached_load_b", 64'(m_nin), 64'(DIM + 3));
      chk("abort_write_before_rst", 64'(r_w), 64'd1);
      in_valid = 0;
      #1 rst_n = 0;
      #1;
      chk("abort_r_w", 64'(r_w), 64'd0);
      chk("abort_addr", 64'(addr), 64'd0);
      chk("abort_dataOut", dataOut, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      run_job(0, 0, 0, 0);   // restart after abort
      for (int j = 0; j < 5; j++) run_job(2, 2, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
